led_adder: RTL and testbench

//  - Adds two 2-bit operands taken from four board switches; shows the 3-bit sum on three LEDs.
//  - Operand A = {sw2, sw1} (sw2 is the MSB); operand B = {sw4, sw3} (sw4 is the MSB).
//  - Top-level user-I/O block: synchronises and debounces the raw switches, then drives LEDs from registers.

---
 rtl/led_adder_pkg.sv | 15 +
 rtl/switch_debounce.sv | 44 ++++
 rtl/led_adder.sv | 48 ++++
 tb/tb_led_adder.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/led_adder_pkg.sv
// Shared widths and types for the switch adder. The helper sizes the debounce counter.
package led_adder_pkg;
  localparam int OPW  = 2;
  localparam int SUMW = OPW + 1;

  typedef logic [OPW-1:0]  operand_t;
  typedef logic [SUMW-1:0] sum_t;

  // Counter width able to hold 0..n, never less than one bit
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/switch_debounce.sv
// One switch lane: 2-flop synchroniser followed by a saturating-free debounce counter.
module switch_debounce
  import led_adder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_pipe;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          stable;

  assign sync     = sync_pipe[1];
  assign o_stable = stable;

  // Two-flop synchroniser for the asynchronous raw switch
  always_ff @(posedge clk) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], i_raw};
  end

  // Stable value only follows sync after it has differed for DEBOUNCE_CYCLES consecutive cycles;
  // any return to agreement restarts the count, so cnt never passes CNT_MAX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/led_adder.sv
// Board I/O top: debounces four switches into two 2-bit operands and shows their sum on three LEDs.
module led_adder
  import led_adder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw1,
  input  logic sw2,
  input  logic sw3,
  input  logic sw4,
  output logic LED_1,
  output logic LED_2,
  output logic LED_3
);
  localparam int NUM_LANES = 2 * OPW;

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] stable;
  operand_t a, b;
  sum_t     led_q;

  // Lane order puts operand A in the low bits, operand B in the high bits
  assign raw = {sw4, sw3, sw2, sw1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (raw[g]),
      .o_stable(stable[g])
    );
  end

  assign a = stable[OPW-1:0];
  assign b = stable[NUM_LANES-1:OPW];

  // Registered sum keeps the LEDs free of any combinational path from the switches
  always_ff @(posedge clk) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= sum_t'(a) + sum_t'(b);
  end

  assign {LED_1, LED_2, LED_3} = led_q;
endmodule

// File: tb/tb_led_adder.sv
// Directed bench for led_adder: table of switch patterns plus hand-written latency/glitch/reset sequences.
module tb_led_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
  logic LED_1, LED_2, LED_3;
  logic m_sw1 = 1'b0, m_sw2 = 1'b0, m_sw3 = 1'b0, m_sw4 = 1'b0;
  logic m_LED_1, m_LED_2, m_LED_3;
  logic [2:0] leds, m_leds;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] sw;   // {sw2,sw1,sw4,sw3}
    logic [2:0] exp;  // {LED_1,LED_2,LED_3}
  } vec_t;
  vec_t tbl [16];
  logic [2:0] exp_lut [16];

  always #5 clk = ~clk;

  led_adder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .sw1(sw1), .sw2(sw2), .sw3(sw3), .sw4(sw4),
    .LED_1(LED_1), .LED_2(LED_2), .LED_3(LED_3)
  );

  led_adder #(.DEBOUNCE_CYCLES(1)) dut_min (
    .clk(clk), .rst_n(rst_n),
    .sw1(m_sw1), .sw2(m_sw2), .sw3(m_sw3), .sw4(m_sw4),
    .LED_1(m_LED_1), .LED_2(m_LED_2), .LED_3(m_LED_3)
  );

  assign leds   = {LED_1, LED_2, LED_3};
  assign m_leds = {m_LED_1, m_LED_2, m_LED_3};

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_sw(input logic [3:0] v);
    {sw2, sw1, sw4, sw3} = v;
  endtask

  initial begin
    exp_lut = '{3'd0, 3'd1, 3'd2, 3'd3,
                3'd1, 3'd2, 3'd3, 3'd4,
                3'd2, 3'd3, 3'd4, 3'd5,
                3'd3, 3'd4, 3'd5, 3'd6};
    for (int i = 0; i < 16; i++) begin
      tbl[i].sw  = 4'(i);
      tbl[i].exp = exp_lut[i];
    end

    // Reset with all switches high
    set_sw(4'b1111);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("reset_cyc%0d", c), leds, 3'b000);
    end
    rst_n = 1'b1;
    tick();
    check("reset_release", leds, 3'b000);

    // Exhaustive switch table
    for (int i = 0; i < 16; i++) begin
      set_sw(tbl[i].sw);
      tick(20);
      check($sformatf("table_i%0d", i), leds, tbl[i].exp);
    end

    // Latency of a held change (sw1 and sw3 together)
    set_sw(4'b0000);
    tick(20);
    check("lat_base", leds, 3'b000);
    sw1 = 1'b1; sw3 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("lat_cyc%0d", c), leds, (c < 7) ? 3'b000 : 3'b010);
    end

    // 3-cycle glitch on sw4 must be rejected
    set_sw(4'b0000);
    tick(20);
    check("glitch_base", leds, 3'b000);
    sw4 = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 3) sw4 = 1'b0;
      check($sformatf("glitch3_cyc%0d", c), leds, 3'b000);
    end

    // Exactly 4-cycle pulse passes
    sw4 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 4) sw4 = 1'b0;
      check($sformatf("pulse4_cyc%0d", c), leds, (c < 7) ? 3'b000 : 3'b010);
    end
    tick(20);
    check("pulse4_return", leds, 3'b000);

    // Reset in the middle of a debounce discards the pending change
    sw2 = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick();
    check("midrst_in_reset", leds, 3'b000);
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("midrst_cyc%0d", c), leds, (c < 7) ? 3'b000 : 3'b010);
    end

    // Minimum filter instance
    tick(5);
    check("min_base", m_leds, 3'b000);
    {m_sw2, m_sw1, m_sw4, m_sw3} = 4'b1111;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("min_cyc%0d", c), m_leds, (c < 4) ? 3'b000 : 3'b110);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
